// File: rtl/lane_serializer.sv
// Parallel-to-beat serializer: splits a WIDTH-bit word into WIDTH/LANES beats of LANES bits,
// MSB- or LSB-first per word, with a one-word holding buffer for back-to-back words.
module lane_serializer #(
  parameter int WIDTH = 100,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             lsb_first_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [LANES-1:0] data_o,
  output logic             valid_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic             dbg_state
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS - 1);

  if ((WIDTH < 1) || (LANES < 1) || (WIDTH % LANES != 0)) begin : g_bad_params
    $error("lane_serializer: WIDTH must be a positive multiple of LANES");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] cnt;
  logic             lsb_first_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_lsb;
  logic             hold_full;

  logic accept;
  logic xfer;
  logic load;

  // Handshake: a word moves on valid_i && ready_o, a beat moves on valid_o && ready_i.
  // valid_o stays high with stable data_o/last_o until its beat transfers.
  assign ready_o   = !hold_full && !reset;
  assign valid_o   = (state == SHIFT);
  assign last_o    = valid_o && (cnt == '0);
  assign data_o    = lsb_first_q ? shifter[LANES-1:0] : shifter[WIDTH-1 -: LANES];
  assign dbg_state = (state == SHIFT);

  assign accept = valid_i && ready_o;
  assign xfer   = valid_o && ready_i;
  // The shifter may take a new word whenever it is empty or its final beat is leaving.
  assign load   = (state == IDLE) || (xfer && last_o);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shifter     <= '0;
      cnt         <= '0;
      lsb_first_q <= 1'b0;
      hold_data   <= '0;
      hold_lsb    <= 1'b0;
      hold_full   <= 1'b0;
    end else if (load) begin
      if (hold_full) begin
        shifter     <= hold_data;
        lsb_first_q <= hold_lsb;
        cnt         <= CNT_LOAD;
        state       <= SHIFT;
        hold_full   <= accept;
        if (accept) begin
          hold_data <= data_i;
          hold_lsb  <= lsb_first_i;
        end
      end else if (accept) begin
        shifter     <= data_i;
        lsb_first_q <= lsb_first_i;
        cnt         <= CNT_LOAD;
        state       <= SHIFT;
      end else begin
        state <= IDLE;
      end
    end else begin
      if (xfer) begin
        shifter <= lsb_first_q ? (shifter >> LANES) : (shifter << LANES);
        cnt     <= cnt - 1'b1;
      end
      if (accept) begin
        hold_data <= data_i;
        hold_lsb  <= lsb_first_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: an 8-bit/2-lane instance and a 4-bit/4-lane instance, each checked
// beat-by-beat against a word-level beat model plus hand-computed literal sequences.
module tb_lane_serializer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: WIDTH=8, LANES=2 ----------------
  logic [7:0] di_a;
  logic       li_a, vi_a, ready_a, valid_a, last_a, rdy_a, dbg_a;
  logic [1:0] dout_a;

  lane_serializer #(.WIDTH(8), .LANES(2)) dut_a (
    .clk(clk), .reset(rst), .data_i(di_a), .lsb_first_i(li_a), .valid_i(vi_a),
    .ready_o(ready_a), .data_o(dout_a), .valid_o(valid_a), .last_o(last_a),
    .ready_i(rdy_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B: WIDTH=4, LANES=4 ----------------
  logic [3:0] di_b;
  logic       li_b, vi_b, ready_b, valid_b, last_b, rdy_b, dbg_b;
  logic [3:0] dout_b;

  lane_serializer #(.WIDTH(4), .LANES(4)) dut_b (
    .clk(clk), .reset(rst), .data_i(di_b), .lsb_first_i(li_b), .valid_i(vi_b),
    .ready_o(ready_b), .data_o(dout_b), .valid_o(valid_b), .last_o(last_b),
    .ready_i(rdy_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [2:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [1:0] obs_a[$];
  int         obs_cyc_a[$];
  logic [3:0] obs_b[$];
  int         obs_cyc_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level model: beat k of an MSB-first word is bits [7-2k:6-2k], LSB-first is [2k+1:2k].
  task automatic push_a(input logic [7:0] w, input logic lsb);
    for (int k = 0; k < 4; k++) begin
      int pos;
      pos = lsb ? (k * 2) : (6 - k * 2);
      exp_a.push_back({(k == 3), 2'((w >> pos) & 8'h3)});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
    end else begin
      if (valid_a) begin
        check("a_beat_pending", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          check("a_beat", 32'({last_a, dout_a}), 32'(exp_a[0]));
          if (rdy_a) begin
            void'(exp_a.pop_front());
            obs_a.push_back(dout_a);
            obs_cyc_a.push_back(cyc);
          end
        end
      end
      if (vi_a && ready_a) push_a(di_a, li_a);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_b.delete();
    end else begin
      if (valid_b) begin
        check("b_beat_pending", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          check("b_beat", 32'({last_b, dout_b}), 32'(exp_b[0]));
          if (rdy_b) begin
            void'(exp_b.pop_front());
            obs_b.push_back(dout_b);
            obs_cyc_b.push_back(cyc);
          end
        end
      end
      if (vi_b && ready_b) exp_b.push_back({1'b1, di_b});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [7:0] d, input logic lsb);
    int n;
    n = 0;
    vi_a = 1'b1; di_a = d; li_a = lsb;
    @(negedge clk);
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_send_accept", 32'(ready_a), 32'd1);
    @(posedge clk); #1;
    vi_a = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d);
    int n;
    n = 0;
    vi_b = 1'b1; di_b = d; li_b = 1'b0;
    @(negedge clk);
    while (!ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_send_accept", 32'(ready_b), 32'd1);
    @(posedge clk); #1;
    vi_b = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while ((valid_a || exp_a.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_drain", 32'(valid_a || exp_a.size() != 0), 32'd0);
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while ((valid_b || exp_b.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_drain", 32'(valid_b || exp_b.size() != 0), 32'd0);
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_cyc_a.delete();
    obs_b.delete(); obs_cyc_b.delete();
  endtask

  // seq packs n 2-bit beats, first beat in the most significant position.
  task automatic check_seq_a(input string name, input int n, input logic [15:0] seq,
                             input bit contig);
    check({name, "_len"}, 32'(obs_a.size()), 32'(n));
    for (int i = 0; i < n && i < obs_a.size(); i++) begin
      check(name, 32'(obs_a[i]), 32'((seq >> (2 * (n - 1 - i))) & 16'h3));
      if (contig) check({name, "_gap"}, 32'(obs_cyc_a[i]), 32'(obs_cyc_a[0] + i));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    vi_a = 1'b0; di_a = '0; li_a = 1'b0; rdy_a = 1'b0;
    vi_b = 1'b0; di_b = '0; li_b = 1'b0; rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_last", 32'(last_a), 32'd0);
    check("rst_data", 32'(dout_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_state", 32'(dbg_a), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready_a", 32'(ready_a), 32'd1);
    check("post_rst_ready_b", 32'(ready_b), 32'd1);

    // 1: MSB-first 0xB4 -> 2,3,1,0, first beat the cycle after accept
    rdy_a = 1'b1;
    clear_obs();
    send_a(8'hB4, 1'b0);
    check("t1_first_valid", 32'(valid_a), 32'd1);
    check("t1_first_data", 32'(dout_a), 32'd2);
    check("t1_first_last", 32'(last_a), 32'd0);
    drain_a();
    check_seq_a("t1_seq", 4, 16'h00B4, 1'b1);
    check("t1_idle_valid", 32'(valid_a), 32'd0);

    // 2: LSB-first 0xB4 -> 0,1,3,2
    clear_obs();
    send_a(8'hB4, 1'b1);
    drain_a();
    check_seq_a("t2_seq", 4, 16'h001E, 1'b1);

    // 3: back-to-back 0xB4 then 0x5A, both MSB-first, no bubble
    clear_obs();
    send_a(8'hB4, 1'b0);
    send_a(8'h5A, 1'b0);
    check("t3_ready_c2", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    check("t3_ready_c3", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    check("t3_ready_c4", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    check("t3_ready_c5", 32'(ready_a), 32'd1);
    drain_a();
    check_seq_a("t3_seq", 8, 16'hB45A, 1'b1);

    // 4: stall for 3 cycles while beat 1 is shown
    clear_obs();
    send_a(8'hB4, 1'b0);
    @(posedge clk); #1;
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_data", 32'(dout_a), 32'd3);
      check("t4_stall_valid", 32'(valid_a), 32'd1);
      @(posedge clk); #1;
    end
    check("t4_after_stall_data", 32'(dout_a), 32'd3);
    rdy_a = 1'b1;
    drain_a();
    check_seq_a("t4_seq", 4, 16'h00B4, 1'b0);

    // 5: reset while beat 2 is shown and the hold buffer is full
    rdy_a = 1'b0;
    send_a(8'hB4, 1'b0);
    send_a(8'h5A, 1'b0);
    rdy_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_a = 1'b0;
    check("t5_beat2_data", 32'(dout_a), 32'd1);
    check("t5_hold_full", 32'(ready_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_valid", 32'(valid_a), 32'd0);
    check("t5_rst_ready", 32'(ready_a), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_release_ready", 32'(ready_a), 32'd1);
    rdy_a = 1'b1;
    clear_obs();
    send_a(8'hFF, 1'b0);
    drain_a();
    check_seq_a("t5_seq", 4, 16'h00FF, 1'b1);

    // mixed words and orders under pseudo-random backpressure
    fork
      begin
        send_a(8'hC3, 1'b0);
        send_a(8'h96, 1'b1);
        send_a(8'h0F, 1'b0);
        send_a(8'hE1, 1'b1);
        send_a(8'h3C, 1'b1);
        send_a(8'h71, 1'b0);
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          rdy_a = 1'($urandom_range(0, 1));
        end
        rdy_a = 1'b1;
      end
    join
    rdy_a = 1'b1;
    drain_a();

    // 6: WIDTH=LANES=4, one word per cycle
    rdy_b = 1'b1;
    clear_obs();
    send_b(4'h1);
    send_b(4'h2);
    send_b(4'h3);
    drain_b();
    check("t6_len", 32'(obs_b.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_b.size(); i++) begin
      check("t6_data", 32'(obs_b[i]), 32'(i + 1));
      check("t6_gap", 32'(obs_cyc_b[i]), 32'(obs_cyc_b[0] + i));
    end

    // single-beat words under stall use the hold buffer
    rdy_b = 1'b0;
    clear_obs();
    send_b(4'h4);
    send_b(4'h5);
    check("t7_hold_full", 32'(ready_b), 32'd0);
    check("t7_stall_data", 32'(dout_b), 32'd4);
    rdy_b = 1'b1;
    drain_b();
    check("t7_len", 32'(obs_b.size()), 32'd2);
    if (obs_b.size() == 2) begin
      check("t7_first", 32'(obs_b[0]), 32'd4);
      check("t7_second", 32'(obs_b[1]), 32'd5);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
